// File: rtl/mem_dma_copy_pkg.sv
// Shared types and constants for the mem_dma_copy block-copy engine.
package mem_dma_copy_pkg;

    localparam int AW_DEF    = 13;
    localparam int DW_DEF    = 16;
    localparam int LW_DEF    = 14;
    localparam int MEM_DEPTH = 8192;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_dma_copy.sv
// Block-copy engine: reads and writes one word at a time, ascending, then pulses done.
// Optional running checksum of copied words when CHECKSUM_EN is defined.
module mem_dma_copy
    import mem_dma_copy_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    state_t        state_r;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [LW-1:0] rem_r;
    logic [DW-1:0] buf_r;

    // The captured word is presented directly as write data during WRITE.
    assign mem_wdata = buf_r;

    // Copy FSM with its pointers and registered memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            src_r     <= {AW{1'b0}};
            dst_r     <= {AW{1'b0}};
            rem_r     <= {LW{1'b0}};
            buf_r     <= {DW{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= {AW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        src_r <= src_addr;
                        dst_r <= dst_addr;
                        rem_r <= len;
                        if (len == LW'(0)) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= ST_READ;
                            busy     <= 1'b1;
                            mem_read <= 1'b1;
                            mem_addr <= src_addr;
                        end
                    end
                end
                ST_READ: begin
                    buf_r     <= mem_rdata;
                    state_r   <= ST_WRITE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_addr  <= dst_r;
                end
                ST_WRITE: begin
                    // Pointers wrap naturally at the address width.
                    src_r     <= src_r + AW'(1);
                    dst_r     <= dst_r + AW'(1);
                    rem_r     <= rem_r - LW'(1);
                    mem_write <= 1'b0;
                    if (rem_r == LW'(1)) begin
                        state_r  <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mem_addr <= {AW{1'b0}};
                    end else begin
                        state_r  <= ST_READ;
                        mem_read <= 1'b1;
                        mem_addr <= src_r + AW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_addr  <= {AW{1'b0}};
                end
            endcase
        end
    end

`ifdef CHECKSUM_EN
    // Modulo-2^DW sum of every word captured in READ; cleared on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= {DW{1'b0}};
        end else if (state_r == ST_IDLE && start) begin
            checksum <= {DW{1'b0}};
        end else if (state_r == ST_READ) begin
            checksum <= checksum + mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_mem_dma_copy.sv
// Directed self-checking bench for mem_dma_copy with a behavioural 8192x16 memory.
module tb_mem_dma_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] src_addr;
    logic [12:0] dst_addr;
    logic [13:0] len;
    logic        busy;
    logic        done;
    logic        mem_read;
    logic        mem_write;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [15:0] mem [0:8191];
    logic        bd_we;
    logic [12:0] bd_addr;
    logic [15:0] bd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, both_cnt = 0, bad_addr_cnt = 0;
    logic [12:0] rd_q [$];
    int d_busy, d_rd, d_wr, d_done, d_both, d_bad, done_cyc, rd_base;

    mem_dma_copy dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write at the rising edge, plus a backdoor port.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    // Activity monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt <= busy_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (mem_write) wr_cnt <= wr_cnt + 1;
            if (mem_read && mem_write) both_cnt <= both_cnt + 1;
            if (!busy && mem_addr != 13'd0) bad_addr_cnt <= bad_addr_cnt + 1;
            if (mem_read) begin
                rd_cnt <= rd_cnt + 1;
                rd_q.push_back(mem_addr);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic bd_write(input int a, input logic [15:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a[12:0];
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // Launch a copy, optionally pulse stray starts at cycles p1/p2, wait for done.
    task automatic run_copy(input int s, input int d, input int n, input int p1, input int p2);
        int b_busy, b_rd, b_wr, b_done, b_both, b_bad;
        @(negedge clk);
        start    = 1'b1;
        src_addr = s[12:0];
        dst_addr = d[12:0];
        len      = n[13:0];
        @(posedge clk);
        b_busy = busy_cnt; b_rd = rd_cnt; b_wr = wr_cnt;
        b_done = done_cnt; b_both = both_cnt; b_bad = bad_addr_cnt;
        rd_base  = rd_q.size();
        done_cyc = 0;
        for (int k = 1; k <= 2 * n + 10; k++) begin
            @(negedge clk);
            if (k == p1 || k == p2) begin
                start    = 1'b1;
                src_addr = 13'd500;
                dst_addr = 13'd600;
                len      = 14'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                start    = 1'b0;
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        d_busy = busy_cnt - b_busy; d_rd = rd_cnt - b_rd; d_wr = wr_cnt - b_wr;
        d_done = done_cnt - b_done; d_both = both_cnt - b_both; d_bad = bad_addr_cnt - b_bad;
    endtask

    task automatic check_run(input string tag, input int n);
        check_eq({tag, "_done_cycle"}, 32'(done_cyc), 32'(2 * n + 1));
        check_eq({tag, "_busy_cycles"}, 32'(d_busy), 32'(2 * n));
        check_eq({tag, "_reads"}, 32'(d_rd), 32'(n));
        check_eq({tag, "_writes"}, 32'(d_wr), 32'(n));
        check_eq({tag, "_done_pulses"}, 32'(d_done), 32'd1);
        check_eq({tag, "_rd_wr_overlap"}, 32'(d_both), 32'd0);
        check_eq({tag, "_idle_addr"}, 32'(d_bad), 32'd0);
    endtask

    initial begin
        int dc0;
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = 13'd0;
        dst_addr = 13'd0;
        len      = 14'd0;
        bd_we    = 1'b0;
        bd_addr  = 13'd0;
        bd_data  = 16'd0;
        #12;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_read", 32'(mem_read), 32'd0);
        check_eq("rst_mem_write", 32'(mem_write), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
`ifdef CHECKSUM_EN
        check_eq("rst_checksum", 32'(checksum), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Basic 10-word copy 100..109 -> 200..209.
        for (int i = 0; i < 10; i++) bd_write(100 + i, 16'(i + 1));
        run_copy(100, 200, 10, -1, -1);
        check_run("copy10", 10);
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("copy10_mem%0d", 200 + i), 32'(mem[200 + i]), 32'(i + 1));
`ifdef CHECKSUM_EN
        check_eq("copy10_checksum", 32'(checksum), 32'd55);
`endif

        // Zero-length copy: no memory access, done right after the start edge.
        run_copy(0, 0, 0, -1, -1);
        check_run("len0", 0);
`ifdef CHECKSUM_EN
        check_eq("len0_checksum", 32'(checksum), 32'd0);
`endif

        // Source pointer wraps 8191 -> 0.
        bd_write(8190, 16'hA1A1);
        bd_write(8191, 16'hB2B2);
        bd_write(0, 16'hC3C3);
        bd_write(1, 16'hD4D4);
        run_copy(8190, 300, 4, -1, -1);
        check_run("wrap", 4);
        check_eq("wrap_mem300", 32'(mem[300]), 32'h0000A1A1);
        check_eq("wrap_mem301", 32'(mem[301]), 32'h0000B2B2);
        check_eq("wrap_mem302", 32'(mem[302]), 32'h0000C3C3);
        check_eq("wrap_mem303", 32'(mem[303]), 32'h0000D4D4);
        check_eq("wrap_rd0", 32'(rd_q[rd_base]), 32'd8190);
        check_eq("wrap_rd1", 32'(rd_q[rd_base + 1]), 32'd8191);
        check_eq("wrap_rd2", 32'(rd_q[rd_base + 2]), 32'd0);
        check_eq("wrap_rd3", 32'(rd_q[rd_base + 3]), 32'd1);

        // Stray starts during a copy are ignored.
        bd_write(500, 16'h5555);
        bd_write(501, 16'h6666);
        bd_write(600, 16'h0BAD);
        bd_write(601, 16'h0BAD);
        run_copy(100, 400, 10, 3, 20);
        check_run("ignore", 10);
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("ignore_mem%0d", 400 + i), 32'(mem[400 + i]), 32'(i + 1));
        check_eq("ignore_mem600", 32'(mem[600]), 32'h00000BAD);
        check_eq("ignore_mem601", 32'(mem[601]), 32'h00000BAD);

        // Asynchronous reset just after the third write has landed.
        for (int i = 0; i < 10; i++) bd_write(200 + i, 16'hFFFF);
        @(posedge clk);
        dc0 = done_cnt;
        @(negedge clk);
        start    = 1'b1;
        src_addr = 13'd100;
        dst_addr = 13'd200;
        len      = 14'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_mem_read", 32'(mem_read), 32'd0);
        check_eq("async_rst_mem_write", 32'(mem_write), 32'd0);
        check_eq("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("async_rst_mem_wdata", 32'(mem_wdata), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        check_eq("async_rst_no_done", 32'(done_cnt - dc0), 32'd0);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("rst_mem%0d", 200 + i), 32'(mem[200 + i]), 32'(i + 1));
        for (int i = 3; i < 10; i++)
            check_eq($sformatf("rst_mem%0d", 200 + i), 32'(mem[200 + i]), 32'h0000FFFF);

        // Normal operation after reset.
        run_copy(100, 700, 3, -1, -1);
        check_run("post_rst", 3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("post_rst_mem%0d", 700 + i), 32'(mem[700 + i]), 32'(i + 1));
`ifdef CHECKSUM_EN
        check_eq("post_rst_checksum", 32'(checksum), 32'd6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
